// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: one-bit-per-cycle shift-add multiplier and restoring
// divider sharing a single FSM, operand latch and {hi,lo} result register.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [1:0]           i_op,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic                 i_cancel,
  output logic                 o_stall,
  output logic                 o_busy,
  output logic                 o_ready,
  output logic [2*WIDTH-1:0]   o_result,
  output logic                 o_div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e               r_state;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic                 r_neg_res;
  logic                 r_neg_rem;
  logic                 r_busy;
  logic                 r_ready;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_dbz;

  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_b_zero;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_step;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;
  logic [2*WIDTH-1:0]   w_final;

  // Signed ops work on magnitudes; signs are re-applied on the DONE entry edge.
  assign w_a_neg  = ~i_op[0] & i_a[WIDTH-1];
  assign w_b_neg  = ~i_op[0] & i_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -i_a : i_a;
  assign w_b_mag  = w_b_neg ? -i_b : i_b;
  assign w_b_zero = (i_b == '0);

  // Multiply: acc = {hi, multiplier}; add multiplicand into hi, shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      {1'b0, (r_acc[0] ? r_opnd : {WIDTH{1'b0}})};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: acc = {rem, quo}; shift left, trial-subtract the divisor.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rem_sh - {1'b0, r_opnd};
  assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_step     = (r_state == StDiv) ? w_div_next : w_mul_next;
  assign w_prod_fix = r_neg_res ? -w_step : w_step;
  assign w_quo_fix  = r_neg_res ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
  assign w_rem_fix  = r_neg_rem ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];
  assign w_final    = (r_state == StDiv) ? {w_rem_fix, w_quo_fix} : w_prod_fix;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      r_result  <= '0;
      r_dbz     <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start && !i_cancel) begin
            r_cnt     <= CW'(WIDTH);
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            if (i_op[1] && w_b_zero) begin
              r_state  <= StDone;
              r_ready  <= 1'b1;
              r_result <= {i_a, {WIDTH{1'b1}}};
              r_dbz    <= 1'b1;
            end else if (i_op[1]) begin
              r_state <= StDiv;
              r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
              r_opnd  <= w_b_mag;
              r_busy  <= 1'b1;
            end else begin
              r_state <= StMul;
              r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
              r_opnd  <= w_a_mag;
              r_busy  <= 1'b1;
            end
          end
        end
        StMul, StDiv: begin
          if (i_cancel) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt - 1'b1;
            // Last iteration folds straight into the sign-corrected result write.
            if (r_cnt == CW'(1)) begin
              r_state  <= StDone;
              r_busy   <= 1'b0;
              r_ready  <= 1'b1;
              r_result <= w_final;
              r_dbz    <= 1'b0;
            end
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_stall       = i_rst_n & ~i_cancel & (((r_state == StIdle) & i_start) | r_busy);
  assign o_busy        = r_busy;
  assign o_ready       = r_ready;
  assign o_result      = r_result;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: table of ops on WIDTH=32 and WIDTH=8 instances,
// plus hand sequences for cancel, cancel-blocked start and mid-op reset.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  op;
  logic        cancel;
  logic        start32, start8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic        stall32, busy32, ready32, dbz32;
  logic [63:0] res32;
  logic        stall8, busy8, ready8, dbz8;
  logic [15:0] res8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.WIDTH(32)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start32), .i_op(op), .i_a(a32), .i_b(b32),
    .i_cancel(cancel), .o_stall(stall32), .o_busy(busy32), .o_ready(ready32),
    .o_result(res32), .o_div_by_zero(dbz32)
  );

  muldiv_iter #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_op(op), .i_a(a8), .i_b(b8),
    .i_cancel(cancel), .o_stall(stall8), .o_busy(busy8), .o_ready(ready8),
    .o_result(res8), .o_div_by_zero(dbz8)
  );

  typedef struct {
    bit          w8;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    bit          dbz;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic sel_ready(input bit w8);
    return w8 ? ready8 : ready32;
  endfunction

  function automatic logic sel_stall(input bit w8);
    return w8 ? stall8 : stall32;
  endfunction

  // Issues one op; returns result/flag and cycles from accept to ready (-1 on timeout).
  task automatic run_op(input vec_t v, output logic [63:0] res, output logic dbz,
                        output int lat);
    bit stall_bad = 1'b0;
    bit got = 1'b0;
    res = '0;
    dbz = 1'b0;
    lat = -1;
    @(posedge clk); #1;
    op = v.op;
    if (v.w8) begin
      a8 = v.a[7:0]; b8 = v.b[7:0]; start8 = 1'b1;
    end else begin
      a32 = v.a; b32 = v.b; start32 = 1'b1;
    end
    #1;
    check("idle_ready", {63'd0, sel_ready(v.w8)}, 64'd0);
    if (!sel_stall(v.w8)) stall_bad = 1'b1;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk); #1;
      start8 = 1'b0; start32 = 1'b0;
      a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
      op = 2'($urandom);
      #1;
      if (sel_ready(v.w8)) begin
        got = 1'b1;
        lat = c;
        if (sel_stall(v.w8)) stall_bad = 1'b1;
        res = v.w8 ? {48'd0, res8} : res32;
        dbz = v.w8 ? dbz8 : dbz32;
      end else if (!sel_stall(v.w8)) begin
        stall_bad = 1'b1;
      end
    end
    check("stall_profile", {63'd0, stall_bad}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] r;
    logic        d;
    int          l;
    logic [63:0] last32;

    vecs[0]  = '{1'b0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 33};
    vecs[1]  = '{1'b0, 2'b00, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1, 1'b0, 33};
    vecs[2]  = '{1'b0, 2'b10, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0, 33};
    vecs[3]  = '{1'b0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 33};
    vecs[4]  = '{1'b0, 2'b11, 32'd100,      32'd0,        64'h00000064_FFFFFFFF, 1'b1, 1};
    vecs[5]  = '{1'b0, 2'b01, 32'd2,        32'd3,        64'h00000000_00000006, 1'b0, 33};
    vecs[6]  = '{1'b0, 2'b11, 32'd1000,     32'd7,        64'h00000006_0000008E, 1'b0, 33};
    vecs[7]  = '{1'b1, 2'b10, 32'h80,       32'h03,       64'h000000000000FED6, 1'b0, 9};
    vecs[8]  = '{1'b1, 2'b01, 32'hFF,       32'hFF,       64'h000000000000FE01, 1'b0, 9};
    vecs[9]  = '{1'b1, 2'b00, 32'h80,       32'hFF,       64'h0000000000000080, 1'b0, 9};
    vecs[10] = '{1'b1, 2'b10, 32'h80,       32'hFF,       64'h0000000000000080, 1'b0, 9};
    vecs[11] = '{1'b1, 2'b11, 32'hFF,       32'h10,       64'h0000000000000F0F, 1'b0, 9};
    vecs[12] = '{1'b0, 2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 33};
    vecs[13] = '{1'b0, 2'b10, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 33};
    vecs[14] = '{1'b0, 2'b10, 32'hFFFFFFFF, 32'd0,        64'hFFFFFFFF_FFFFFFFF, 1'b1, 1};
    vecs[15] = '{1'b0, 2'b11, 32'hFFFFFFFF, 32'd16,       64'h0000000F_0FFFFFFF, 1'b0, 33};

    rst_n = 1'b0; op = 2'b00; cancel = 1'b0;
    start32 = 1'b1; start8 = 1'b0;
    a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    #12;
    check("rst_result", res32, 64'd0);
    check("rst_busy", {63'd0, busy32}, 64'd0);
    check("rst_ready", {63'd0, ready32}, 64'd0);
    check("rst_dbz", {63'd0, dbz32}, 64'd0);
    check("rst_stall", {63'd0, stall32}, 64'd0);
    start32 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    last32 = '0;
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i], r, d, l);
      check($sformatf("v%0d_result", i), r, vecs[i].res);
      check($sformatf("v%0d_dbz", i), {63'd0, d}, {63'd0, vecs[i].dbz});
      check($sformatf("v%0d_latency", i), 64'(l), 64'(vecs[i].lat));
      if (!vecs[i].w8) last32 = vecs[i].res;
    end

    // Cancel a signed DIV in cycle 10.
    @(posedge clk); #1;
    op = 2'b10; a32 = 32'd1000; b32 = 32'd7; start32 = 1'b1;
    #1;
    check("cancel_accept_stall", {63'd0, stall32}, 64'd1);
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
      start32 = 1'b0;
    end
    @(posedge clk); #1;
    cancel = 1'b1;
    #1;
    check("cancel_stall_low", {63'd0, stall32}, 64'd0);
    @(posedge clk); #1;
    cancel = 1'b0;
    #1;
    check("cancel_busy", {63'd0, busy32}, 64'd0);
    check("cancel_ready", {63'd0, ready32}, 64'd0);
    check("cancel_result_kept", res32, last32);
    run_op('{1'b0, 2'b11, 32'd1000, 32'd7, 64'h00000006_0000008E, 1'b0, 33}, r, d, l);
    check("after_cancel_result", r, 64'h00000006_0000008E);
    check("after_cancel_latency", 64'(l), 64'd33);

    // Cancel in IDLE blocks a same-cycle start.
    @(posedge clk); #1;
    op = 2'b01; a32 = 32'd2; b32 = 32'd3; start32 = 1'b1; cancel = 1'b1;
    #1;
    check("idle_cancel_stall", {63'd0, stall32}, 64'd0);
    @(posedge clk); #1;
    start32 = 1'b0; cancel = 1'b0;
    #1;
    check("idle_cancel_busy", {63'd0, busy32}, 64'd0);

    // Reset in cycle 5 of a MULT.
    @(posedge clk); #1;
    op = 2'b00; a32 = 32'hFFFFFFFD; b32 = 32'd5; start32 = 1'b1;
    for (int c = 1; c < 5; c++) begin
      @(posedge clk); #1;
      start32 = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b0; start32 = 1'b1;
    #1;
    check("midrst_result", res32, 64'd0);
    check("midrst_busy", {63'd0, busy32}, 64'd0);
    check("midrst_ready", {63'd0, ready32}, 64'd0);
    check("midrst_stall", {63'd0, stall32}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; start32 = 1'b0;
    run_op('{1'b0, 2'b01, 32'd2, 32'd3, 64'd6, 1'b0, 33}, r, d, l);
    check("postrst_result", r, 64'd6);
    check("postrst_latency", 64'(l), 64'd33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised iterative multiply/divide unit for the execute stage: one-bit-per-cycle shift-add multiplier and restoring divider sharing one FSM, operand latch and result register. It replaces the fixed 32-bit `div`/`mul2` pair with a single `WIDTH`-generic block. It adds a flush-driven cancel, a divide-by-zero fast path and flag, and a registered `{hi,lo}` result for the HI/LO file. The ALU drives `start` while a MULT/DIV sits in E and stalls the front end on `stall`.

## Interface
- `WIDTH`, default 32, operand width; even, ≥ 4; result is `2*WIDTH`.
- `clk  in  1`  rising-edge clock.
- `rst  in  1`  asynchronous reset, active-low (0 = reset).
- `start  in  1`  request; sampled only in IDLE.
- `op  in  2`  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a  in  WIDTH`  multiplicand / dividend; sampled with `start`.
- `b  in  WIDTH`  multiplier / divisor; sampled with `start`.
- `cancel  in  1`  flush; aborts any operation in flight.
- `stall  out  1`  pipeline hold request (combinational).
- `busy  out  1`  registered; high in MUL/DIV states.
- `ready  out  1`  registered one-cycle completion pulse.
- `result  out  2*WIDTH`  MUL: full product `{hi,lo}`; DIV: `{remainder, quotient}`.
- `div_by_zero  out  1`  registered; valid with `ready`, held until next completion.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE: `start & ~cancel` accepts the request.
  - Latch `|a|`, `|b|` (magnitudes for signed ops, raw for unsigned), the op and the result signs.
  - Load the iteration counter with `WIDTH`.
  - Go to MUL (op[1]=0) or DIV (op[1]=1).
- DIV with `b==0`: skip iteration and go directly to DONE.
  - `result = {a, {WIDTH{1'b1}}}` (remainder = original `a`, quotient = all ones), `div_by_zero=1`.
- MUL: each cycle, if multiplier LSB is set, add the multiplicand to the upper accumulator, then shift right 1. Counter decrements. At 0, go to DONE.
- DIV: restoring step per cycle: shift `{rem,quo}` left 1, trial-subtract divisor from rem. If non-negative, keep it and set quo LSB. Counter decrements. At 0, go to DONE.
- DONE entry edge applies sign correction and writes `result`:
  - MULT: negate the 2W product if `a[W-1]^b[W-1]`.
  - DIV: negate quotient if the signs differ; negate remainder if `a` is negative.
  - `div_by_zero=0` for all non-zero-divisor ops.
- DONE: `ready=1` for exactly one cycle, then IDLE unconditionally. `start` is ignored in DONE.
- Signed overflow: `MIN / -1` yields quotient `MIN` (wraps) and remainder 0, with no flag.
- MULT/MULTU product is exact; no overflow exists.
- `cancel` in MUL/DIV/DONE: next state IDLE.
  - `ready` is not asserted; a pending DONE pulse is suppressed.
  - `result` and `div_by_zero` keep their previous values.
  - In IDLE, `cancel` blocks acceptance of a same-cycle `start`.
- `result` changes only on the DONE entry edge or reset.

## Timing
- Reset (`rst`=0, async): state IDLE, `busy=0`, `ready=0`, `result=0`, `div_by_zero=0`, counter 0. `stall` is forced 0 while `rst`=0.
- Accept cycle = cycle 0. MUL/DIV occupy cycles 1..WIDTH. DONE is cycle WIDTH+1, with `ready=1` and `result` valid. IDLE is cycle WIDTH+2.
- Latency start→ready is WIDTH+1 cycles (33 for WIDTH=32). Divide-by-zero: `ready` in cycle 1.
- `stall = ((state==IDLE) & start & ~cancel) | busy`.
  - High in cycles 0..WIDTH; low in DONE, so the pipeline advances in the same cycle the result is valid.
  - Low in any cycle where `cancel=1`.
- Back-to-back: the earliest next accept is the IDLE cycle after DONE, giving a throughput of one op per WIDTH+2 cycles.
- `a`/`b`/`op` may change freely after cycle 0.
- Reset asserted mid-operation aborts immediately; no `ready` pulse, and `result` clears to 0.

## Test plan
- WIDTH=32 MULTU `0xFFFFFFFF*0xFFFFFFFF` → `ready` exactly 33 cycles after accept, `result=0xFFFFFFFE_00000001`. `stall` is high for cycles 0..32 and low on the `ready` cycle.
- WIDTH=32 MULT `-3*5` → `0xFFFFFFFF_FFFFFFF1`. DIV `-7/2` → quotient `0xFFFFFFFD`, remainder `0xFFFFFFFF`. DIV `0x80000000/0xFFFFFFFF` → quotient `0x80000000`, remainder 0.
- DIVU `100/0` → `ready` in cycle 1, `div_by_zero=1`, `result={0x00000064,0xFFFFFFFF}`. The following MULTU `2*3` → `result=6`, `div_by_zero=0`.
- DIV `1000/7` with `cancel` pulsed in cycle 10 → IDLE next cycle, no `ready`, `result` unchanged. A new DIVU `1000/7` accepted the following cycle → quotient 142, remainder 6 after 33 cycles.
- WIDTH=8: DIV `0x80/0x03` → quotient `0xD6`, remainder `0xFE`, ready 9 cycles after accept. MULTU `0xFF*0xFF` → `0xFE01`.
- `rst` low in cycle 5 of a MULT → all outputs 0 asynchronously, no `ready`. After release, `start` is accepted on the first IDLE cycle and completes normally.
